// File: rtl/onchip_mem_pkg.sv
// Shared constants and types for the on-chip RAM arbiter slice.
package onchip_mem_pkg;
  localparam int ONCHIP_DEPTH = 45000;
  localparam int ONCHIP_AW    = 16;
  localparam int ONCHIP_DW    = 32;
  localparam int ONCHIP_BE_W  = 4;

  typedef enum logic {
    P0 = 1'b0,
    P1 = 1'b1
  } port_id_t;
endpackage

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-requester arbiter: req[1:0] -> one-hot gnt[1:0].
// Default: round-robin, the port that did not win last takes a tie.
// ONCHIP_ARB_FIXED_PRIO_EN: port 0 always wins a tie, no history kept.
import onchip_mem_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
  // Port 0 has strict priority; port 1 only wins when port 0 is idle.
  always_comb begin
    gnt = 2'b00;
    if (req[0])      gnt = 2'b01;
    else if (req[1]) gnt = 2'b10;
  end
`else
  port_id_t last;

  // Tie goes to the port that is not 'last'; lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == P1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the most recent winner; reset to P1 so P0 takes the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    last <= P1;
    else if (|gnt)   last <= gnt[1] ? P1 : P0;
  end
`endif

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-port Avalon-MM arbiter in front of the single-port on-chip RAM.
// One grant per cycle, 1-cycle read return, out-of-range accesses trapped.
// Build option: ONCHIP_ARB_FIXED_PRIO_EN (port 0 fixed priority).
import onchip_mem_pkg::*;

module onchip_mem_arbiter #(
  parameter int DEPTH = ONCHIP_DEPTH,
  parameter int AW    = ONCHIP_AW
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [AW-1:0]          p0_address,
  input  logic [ONCHIP_BE_W-1:0] p0_byteenable,
  input  logic                   p0_read,
  input  logic                   p0_write,
  input  logic [ONCHIP_DW-1:0]   p0_writedata,
  output logic                   p0_waitrequest,
  output logic [ONCHIP_DW-1:0]   p0_readdata,
  output logic                   p0_readdatavalid,
  input  logic [AW-1:0]          p1_address,
  input  logic [ONCHIP_BE_W-1:0] p1_byteenable,
  input  logic                   p1_read,
  input  logic                   p1_write,
  input  logic [ONCHIP_DW-1:0]   p1_writedata,
  output logic                   p1_waitrequest,
  output logic [ONCHIP_DW-1:0]   p1_readdata,
  output logic                   p1_readdatavalid,
  output logic [AW-1:0]          mem_address,
  output logic [ONCHIP_BE_W-1:0] mem_byteenable,
  output logic                   mem_chipselect,
  output logic                   mem_write,
  output logic [ONCHIP_DW-1:0]   mem_writedata,
  output logic                   mem_clken,
  input  logic [ONCHIP_DW-1:0]   mem_readdata,
  output logic                   err,
  output logic [AW-1:0]          err_addr,
  output logic                   err_port,
  input  logic                   err_clr
);

  logic [1:0]           req, gnt;
  logic                 any_gnt;
  port_id_t             win;
  logic [AW-1:0]        w_addr;
  logic [ONCHIP_BE_W-1:0] w_be;
  logic [ONCHIP_DW-1:0] w_wdata;
  logic                 w_read, w_write;
  logic                 oor;
  logic [1:0]           rd_pend;
  logic                 rd_oor;
  logic [ONCHIP_DW-1:0] rd_data;
  port_id_t             err_port_q;

  assign req = {p1_read | p1_write, p0_read | p0_write};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  assign any_gnt = |gnt;
  assign win     = gnt[1] ? P1 : P0;

  // Command mux: winner's fields drive the RAM side.
  always_comb begin
    w_addr  = p0_address;
    w_be    = p0_byteenable;
    w_wdata = p0_writedata;
    w_read  = p0_read;
    w_write = p0_write;
    if (win == P1) begin
      w_addr  = p1_address;
      w_be    = p1_byteenable;
      w_wdata = p1_writedata;
      w_read  = p1_read;
      w_write = p1_write;
    end
  end

  // Zero-extend before the compare so DEPTH is judged as an unsigned count.
  assign oor = any_gnt && ({{(32-AW){1'b0}}, w_addr} >= 32'(DEPTH));

  assign mem_address    = w_addr;
  assign mem_byteenable = w_be;
  assign mem_writedata  = w_wdata;
  assign mem_chipselect = any_gnt & ~oor;
  assign mem_write      = any_gnt & ~oor & w_write;
  assign mem_clken      = reset_n;

  assign p0_waitrequest = req[0] & ~gnt[0];
  assign p1_waitrequest = req[1] & ~gnt[1];

  // Read-return tracking: which port gets data next cycle, and whether it is a trapped read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= 2'b00;
      rd_oor  <= 1'b0;
    end else begin
      rd_pend <= {gnt[1] & p1_read, gnt[0] & p0_read};
      rd_oor  <= oor & w_read;
    end
  end

  assign rd_data          = rd_oor ? '0 : mem_readdata;
  assign p0_readdata      = rd_data;
  assign p1_readdata      = rd_data;
  assign p0_readdatavalid = rd_pend[0];
  assign p1_readdatavalid = rd_pend[1];

  // Sticky first-fault capture; a clear in the same cycle beats a new fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err        <= 1'b0;
      err_addr   <= '0;
      err_port_q <= P0;
    end else if (err_clr) begin
      err        <= 1'b0;
      err_addr   <= '0;
      err_port_q <= P0;
    end else if (oor && !err) begin
      err        <= 1'b1;
      err_addr   <= w_addr;
      err_port_q <= win;
    end
  end

  assign err_port = err_port_q;

endmodule
